// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared types and helpers for the on-screen game logic.
//   coord_t      : 10-bit pixel coordinate / half-size
//   hit_state_t  : phases of the target hit detector
//   abs_diff()   : 11-bit unsigned |a - b| of two coordinates
// ---------------------------------------------------------------------------
package game_pkg;

    typedef logic [9:0] coord_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DWELL    = 2'd1,
        PRESS    = 2'd2,
        COOLDOWN = 2'd3
    } hit_state_t;

    // Widened by one bit so the difference can never wrap.
    function automatic logic [10:0] abs_diff(input coord_t a, input coord_t b);
        logic [10:0] wa;
        logic [10:0] wb;
        wa = {1'b0, a};
        wb = {1'b0, b};
        return (wa >= wb) ? (wa - wb) : (wb - wa);
    endfunction

endpackage

// File: rtl/box_overlap.sv
// ---------------------------------------------------------------------------
// box_overlap
// Purely combinational test of whether two centred square boxes touch or
// overlap. Boxes sharing an edge pixel count as overlapping.
// Ports:
//   cur_x, cur_y, cur_s : first box centre and half-size
//   tgt_x, tgt_y, tgt_s : second box centre and half-size
//   overlap             : 1 when the boxes touch or overlap
// ---------------------------------------------------------------------------
module box_overlap
    import game_pkg::*;
(
    input  coord_t cur_x,
    input  coord_t cur_y,
    input  coord_t cur_s,
    input  coord_t tgt_x,
    input  coord_t tgt_y,
    input  coord_t tgt_s,
    output logic   overlap
);

    logic [10:0] dx;
    logic [10:0] dy;
    logic [10:0] lim;

    // The half-sizes are summed in 11 bits so two large boxes never wrap.
    always_comb begin
        dx      = abs_diff(cur_x, tgt_x);
        dy      = abs_diff(cur_y, tgt_y);
        lim     = {1'b0, cur_s} + {1'b0, tgt_s};
        overlap = (dx <= lim) && (dy <= lim);
    end

endmodule

// File: rtl/target_hit_detector.sv
// ---------------------------------------------------------------------------
// target_hit_detector
// Scores a hit when the player cursor box stays on the target box for
// DWELL_FRAMES consecutive frames, then pulses the target mover's Pressed
// input for PRESS_FRAMES frames and ignores the target for COOLDOWN_FRAMES.
// Ports:
//   frame_clk  : frame clock, everything on posedge
//   Reset_n    : synchronous active-low reset
//   Enable     : 0 forces the detector idle (score is kept)
//   CursorX/Y/S: cursor centre and half-size
//   TargetX/Y/S: target centre and half-size from the target mover
//   InTarget   : registered overlap flag
//   Pressed    : registered advance request to the target mover
//   Hit        : one-frame pulse per scored hit
//   Score      : saturating hit counter
// ---------------------------------------------------------------------------
module target_hit_detector
    import game_pkg::*;
#(
    parameter int DWELL_FRAMES    = 30,
    parameter int PRESS_FRAMES    = 2,
    parameter int COOLDOWN_FRAMES = 60,
    parameter int SCORE_W         = 8
) (
    input  logic               frame_clk,
    input  logic               Reset_n,
    input  logic               Enable,
    input  logic [9:0]         CursorX,
    input  logic [9:0]         CursorY,
    input  logic [9:0]         CursorS,
    input  logic [9:0]         TargetX,
    input  logic [9:0]         TargetY,
    input  logic [9:0]         TargetS,
    output logic               InTarget,
    output logic               Pressed,
    output logic               Hit,
    output logic [SCORE_W-1:0] Score
);

    localparam logic [15:0] DWELL_LAST = 16'(DWELL_FRAMES - 1);
    localparam logic [15:0] PRESS_LAST = 16'(PRESS_FRAMES - 1);
    localparam logic [15:0] COOL_LAST  = 16'(COOLDOWN_FRAMES - 1);

    hit_state_t         state_q, state_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               in_target_q, in_target_d;
    logic               pressed_q, pressed_d;
    logic               hit_q, hit_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               overlap;
    logic               entering_press;

    box_overlap u_box_overlap (
        .cur_x  (CursorX),
        .cur_y  (CursorY),
        .cur_s  (CursorS),
        .tgt_x  (TargetX),
        .tgt_y  (TargetY),
        .tgt_s  (TargetS),
        .overlap(overlap)
    );

    // Phase sequencing. The FSM works off the registered overlap flag, so
    // the dwell count lines up with the frames on which InTarget was seen
    // high. cnt is reused as the frame counter of whichever phase is active.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_target_q) begin
                    if (DWELL_FRAMES == 1) begin
                        state_d = PRESS;
                        cnt_d   = 16'd0;
                    end else begin
                        state_d = DWELL;
                        cnt_d   = 16'd1;
                    end
                end
            end
            DWELL: begin
                if (!in_target_q) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else if (cnt_q == DWELL_LAST) begin
                    state_d = PRESS;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            PRESS: begin
                if (cnt_q == PRESS_LAST) begin
                    state_d = COOLDOWN;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COOLDOWN: begin
                if (cnt_q == COOL_LAST) begin
                    state_d = IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase

        // Disabling aborts any phase, including an in-flight press.
        if (!Enable) begin
            state_d = IDLE;
            cnt_d   = 16'd0;
        end
    end

    // Outputs derived from the next state so they are registered and line
    // up with the state they describe. A hit is scored only on the edge that
    // enters PRESS, and the score sticks at all-ones rather than wrapping.
    always_comb begin
        entering_press = (state_d == PRESS) && (state_q != PRESS);
        hit_d          = entering_press;
        pressed_d      = (state_d == PRESS);
        in_target_d    = overlap & Enable;
        score_d        = score_q;
        if (entering_press && (score_q != {SCORE_W{1'b1}})) begin
            score_d = score_q + SCORE_W'(1);
        end
    end

    always_ff @(posedge frame_clk) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= 16'd0;
            in_target_q <= 1'b0;
            pressed_q   <= 1'b0;
            hit_q       <= 1'b0;
            score_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            in_target_q <= in_target_d;
            pressed_q   <= pressed_d;
            hit_q       <= hit_d;
            score_q     <= score_d;
        end
    end

    assign InTarget = in_target_q;
    assign Pressed  = pressed_q;
    assign Hit      = hit_q;
    assign Score    = score_q;

endmodule
